// File: rtl/zoi_cpu.sv
// zoi_cpu: multicycle RV32I-subset core with an 8-bit datapath.
// Every instruction takes five cycles: FETCH, DECODE, EXEC, MEM, WB.
// Instructions are 32-bit RV32I encodings. Registers, PC and data addresses
// are 8 bits wide, and all arithmetic wraps mod 256.
// The instruction ROM (mem) is preloaded hierarchically. The data RAM is
// 256x8 with synchronous access.
// Address 0xFC is memory-mapped I/O: a load reads E and a store writes S.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-low reset
//   E          external input, read by a load from 0xFC
//   S          output register, written by a store to 0xFC
//   pc         current instruction index
//   instr      latched instruction
//   srcA/srcB  latched ALU operands
//   ALUResult  latched ALU result
//   readData   latched memory/I/O read data
//   WD3/A3     register write data/address (A3 = 0 when nothing is written)
module zoi_cpu #(
  parameter int    N          = 8,
  parameter int    WIDTH      = 32,
  parameter int    ADDR_WIDTH = 5,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N-1:0]          E,
  output logic [N-1:0]          S,
  output logic [N-1:0]          pc,
  output logic [WIDTH-1:0]      instr,
  output logic [N-1:0]          srcA,
  output logic [N-1:0]          srcB,
  output logic [N-1:0]          ALUResult,
  output logic [N-1:0]          readData,
  output logic [N-1:0]          WD3,
  output logic [ADDR_WIDTH-1:0] A3
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;

  localparam logic [6:0]   OP_LOAD   = 7'b0000011;
  localparam logic [6:0]   OP_STORE  = 7'b0100011;
  localparam logic [6:0]   OP_IMM    = 7'b0010011;
  localparam logic [6:0]   OP_REG    = 7'b0110011;
  localparam logic [6:0]   OP_BRANCH = 7'b1100011;
  localparam logic [6:0]   OP_JAL    = 7'b1101111;
  localparam logic [N-1:0] IO_ADDR   = N'('hFC);

  logic [WIDTH-1:0] mem  [0:(1<<N)-1];
  logic [N-1:0]     ram  [0:(1<<N)-1];
  logic [N-1:0]     rf_q [0:(1<<ADDR_WIDTH)-1];

  state_t                state_q, state_d;
  logic [N-1:0]          pc_q, pc_d, s_q, s_d;
  logic [WIDTH-1:0]      instr_q, instr_d;
  logic [N-1:0]          srcA_q, srcA_d, srcB_q, srcB_d, sdata_q, sdata_d;
  logic [N-1:0]          alu_q, alu_d, rdata_q, rdata_d, wd3_q, wd3_d;
  logic [ADDR_WIDTH-1:0] a3_q, a3_d;
  logic                  br_q, br_d;

  // Instruction fields
  logic [6:0]            opcode, funct7;
  logic [2:0]            funct3;
  logic [ADDR_WIDTH-1:0] rd, rs1, rs2;
  logic [N-1:0]          i_imm, s_imm, b_off, j_off;

  assign opcode = instr_q[6:0];
  assign rd     = instr_q[11:7];
  assign funct3 = instr_q[14:12];
  assign rs1    = instr_q[19:15];
  assign rs2    = instr_q[24:20];
  assign funct7 = instr_q[31:25];

  // Low 8 bits of the sign-extended immediates. For branch and jump targets
  // this is bits [9:2] of the byte offset, i.e. the offset in words.
  assign i_imm = instr_q[27:20];
  assign s_imm = {instr_q[27:25], instr_q[11:7]};
  assign b_off = {instr_q[29:25], instr_q[11:9]};
  assign j_off = instr_q[29:22];

  // Unsupported opcodes and funct3 values fall through as NOPs.
  logic is_load, is_store, is_imm, is_reg, is_br, is_jal, writes_rd;
  assign is_load   = (opcode == OP_LOAD) && (funct3 == 3'b010);
  assign is_store  = (opcode == OP_STORE);
  assign is_imm    = (opcode == OP_IMM) && (funct3 != 3'b011);
  assign is_reg    = (opcode == OP_REG) && (funct3 != 3'b011);
  assign is_br     = (opcode == OP_BRANCH) && (funct3[2:1] == 2'b00);
  assign is_jal    = (opcode == OP_JAL);
  assign writes_rd = is_load | is_imm | is_reg | is_jal;

  function automatic logic [N-1:0] alu_fn(input logic [2:0] f3, input logic sub,
                                          input logic [N-1:0] a, input logic [N-1:0] b);
    logic signed [N-1:0] sa, sb;
    sa = a;
    sb = b;
    case (f3)
      3'b000:  alu_fn = sub ? (a - b) : (a + b);
      3'b001:  alu_fn = a << b[2:0];
      3'b010:  alu_fn = (sa < sb) ? N'(1) : '0;
      3'b100:  alu_fn = a ^ b;
      3'b101:  alu_fn = a >> b[2:0];
      3'b110:  alu_fn = a | b;
      3'b111:  alu_fn = a & b;
      default: alu_fn = '0;
    endcase
  endfunction

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE:  state_d = EXEC;
      EXEC:    state_d = MEM;
      MEM:     state_d = WB;
      WB:      state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  logic [N-1:0] rs1_val, rs2_val, mem_rd, alu_res;
  logic [2:0]   alu_f3;
  logic         alu_sub;

  always_comb begin
    rs1_val = (rs1 == '0) ? '0 : rf_q[rs1];
    rs2_val = (rs2 == '0) ? '0 : rf_q[rs2];
    mem_rd  = (alu_q == IO_ADDR) ? E : ram[alu_q];
    // Loads and stores use the adder for address generation.
    alu_f3  = (is_imm || is_reg) ? funct3 : 3'b000;
    alu_sub = (is_reg && funct7 == 7'b0100000) || is_br;
    alu_res = alu_fn(alu_f3, alu_sub, srcA_q, srcB_q);
  end

  always_comb begin
    instr_d = instr_q;
    srcA_d  = srcA_q;
    srcB_d  = srcB_q;
    sdata_d = sdata_q;
    alu_d   = alu_q;
    br_d    = br_q;
    rdata_d = rdata_q;
    a3_d    = a3_q;
    wd3_d   = wd3_q;
    s_d     = s_q;
    pc_d    = pc_q;
    case (state_q)
      // FETCH: latch the ROM word at pc
      FETCH: instr_d = mem[pc_q];
      // DECODE: register read and operand select
      DECODE: begin
        srcA_d  = rs1_val;
        srcB_d  = (is_load || is_imm) ? i_imm : (is_store ? s_imm : rs2_val);
        sdata_d = rs2_val;
      end
      // EXEC: ALU result and branch decision (funct3[0] selects bne)
      EXEC: begin
        alu_d = alu_res;
        br_d  = is_br && ((srcA_q == srcB_q) ^ funct3[0]);
      end
      // MEM: RAM / I/O access and write-back operands
      MEM: begin
        rdata_d = mem_rd;
        a3_d    = (writes_rd) ? rd : '0;
        wd3_d   = is_load ? mem_rd : (is_jal ? (pc_q + N'(1)) : alu_q);
        if (is_store && alu_q == IO_ADDR) s_d = sdata_q;
      end
      // WB: register write happens in the register file; PC update here
      WB: begin
        if (is_jal)    pc_d = pc_q + j_off;
        else if (br_q) pc_d = pc_q + b_off;
        else           pc_d = pc_q + N'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      pc_q    <= '0;
      s_q     <= '0;
      instr_q <= '0;
      srcA_q  <= '0;
      srcB_q  <= '0;
      sdata_q <= '0;
      alu_q   <= '0;
      br_q    <= 1'b0;
      rdata_q <= '0;
      a3_q    <= '0;
      wd3_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      s_q     <= s_d;
      instr_q <= instr_d;
      srcA_q  <= srcA_d;
      srcB_q  <= srcB_d;
      sdata_q <= sdata_d;
      alu_q   <= alu_d;
      br_q    <= br_d;
      rdata_q <= rdata_d;
      a3_q    <= a3_d;
      wd3_q   <= wd3_d;
    end
  end

  // a3_q is zero for non-writing instructions, which also protects x0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < (1 << ADDR_WIDTH); i++) rf_q[i] <= '0;
    end else if (state_q == WB && a3_q != '0) begin
      rf_q[a3_q] <= wd3_q;
    end
  end

  // An asserted reset forces state_q to FETCH, so an abandoned store never lands.
  always_ff @(posedge clock) begin
    if (state_q == MEM && is_store && alu_q != IO_ADDR) ram[alu_q] <= sdata_q;
  end

  assign S         = s_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign srcA      = srcA_q;
  assign srcB      = srcB_q;
  assign ALUResult = alu_q;
  assign readData  = rdata_q;
  assign WD3       = wd3_q;
  assign A3        = a3_q;

endmodule

// File: tb/tb_zoi_cpu.sv
module tb_zoi_cpu;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  E = 8'h00;
  logic [7:0]  S, pc, srcA, srcB, ALUResult, readData, WD3;
  logic [31:0] instr;
  logic [4:0]  A3;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] LD  = 7'b0000011;

  zoi_cpu dut (
    .clock(clock), .reset(reset), .E(E), .S(S), .pc(pc), .instr(instr),
    .srcA(srcA), .srcB(srcB), .ALUResult(ALUResult), .readData(readData),
    .WD3(WD3), .A3(A3)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic load_rom();
    for (int i = 0; i < 256; i++) dut.mem[i] = 32'h0000_0013;
    dut.mem[8'h00] = 32'hDEADBEEF;                                     // jal x29, ->0x7A
    dut.mem[8'h7A] = enc_i(12'h0FC, 5'd0, 3'b010, 5'd24, LD);          // lw x24,252(x0)
    dut.mem[8'h7B] = enc_i(12'h0AA, 5'd24, 3'b111, 5'd29, OPI);        // andi x29,x24,0xAA
    dut.mem[8'h7C] = enc_i(12'h05A, 5'd0, 3'b000, 5'd1, OPI);          // addi x1,x0,0x5A
    dut.mem[8'h7D] = enc_s(12'h0FC, 5'd1, 5'd0);                       // sw x1,252(x0)
    dut.mem[8'h7E] = enc_s(12'h010, 5'd1, 5'd0);                       // sw x1,16(x0)
    dut.mem[8'h7F] = enc_i(12'h010, 5'd0, 3'b010, 5'd2, LD);           // lw x2,16(x0)
    dut.mem[8'h80] = enc_i(12'hFFF, 5'd0, 3'b000, 5'd3, OPI);          // addi x3,x0,-1
    dut.mem[8'h81] = enc_i(12'h001, 5'd3, 3'b000, 5'd3, OPI);          // addi x3,x3,1
    dut.mem[8'h82] = enc_i(12'h005, 5'd0, 3'b000, 5'd0, OPI);          // addi x0,x0,5
    dut.mem[8'h83] = enc_b(13'd8, 5'd0, 5'd3, 3'b000);                 // beq x3,x0,+2
    dut.mem[8'h84] = enc_i(12'h011, 5'd0, 3'b000, 5'd4, OPI);          // skipped
    dut.mem[8'h85] = enc_b(13'd8, 5'd0, 5'd3, 3'b001);                 // bne x3,x0 (not taken)
    dut.mem[8'h86] = enc_r(7'd0, 5'd24, 5'd1, 3'b000, 5'd5);           // add x5,x1,x24
    dut.mem[8'h87] = enc_r(7'b0100000, 5'd24, 5'd1, 3'b000, 5'd6);     // sub x6,x1,x24
    dut.mem[8'h88] = enc_r(7'd0, 5'd1, 5'd24, 3'b010, 5'd7);           // slt x7,x24,x1
    dut.mem[8'h89] = enc_i(12'h003, 5'd1, 3'b001, 5'd8, OPI);          // slli x8,x1,3
    dut.mem[8'h8A] = enc_i(12'h004, 5'd24, 3'b101, 5'd9, OPI);         // srli x9,x24,4
    dut.mem[8'h8B] = enc_r(7'd0, 5'd24, 5'd1, 3'b100, 5'd10);          // xor x10,x1,x24
    dut.mem[8'h8C] = {20'h12345, 5'd12, 7'b0110111};                   // unsupported opcode
    dut.mem[8'h8D] = enc_i(12'h005, 5'd1, 3'b011, 5'd13, OPI);         // sltiu: unsupported
    dut.mem[8'h8E] = enc_j(21'h001C4, 5'd14);                          // jal x14, ->0xFF
    dut.mem[8'hFF] = enc_i(12'h007, 5'd0, 3'b000, 5'd11, OPI);         // addi x11,x0,7
  endtask

  task automatic run_instr();
    repeat (5) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    @(negedge clock); @(negedge clock);
    n_checks++; if (pc !== 8'h00) $display("FAIL reset_pc: got %h want 00", pc); else n_pass++;
    n_checks++; if (S !== 8'h00) $display("FAIL reset_S: got %h want 00", S); else n_pass++;
    n_checks++; if (instr !== 32'h0) $display("FAIL reset_instr: got %h want 0", instr); else n_pass++;
    n_checks++; if ({srcA, srcB, ALUResult, readData, WD3} !== 40'h0)
      $display("FAIL reset_datapath: got %h want 0", {srcA, srcB, ALUResult, readData, WD3}); else n_pass++;
    n_checks++; if (A3 !== 5'd0) $display("FAIL reset_A3: got %0d want 0", A3); else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_jump();
    run_instr();
    n_checks++; if (instr !== 32'hDEADBEEF) $display("FAIL jal_instr: got %h want deadbeef", instr); else n_pass++;
    n_checks++; if (pc !== 8'h7A) $display("FAIL jal_pc: got %h want 7a", pc); else n_pass++;
    n_checks++; if (A3 !== 5'd29) $display("FAIL jal_A3: got %0d want 29", A3); else n_pass++;
    n_checks++; if (dut.rf_q[29] !== 8'h01) $display("FAIL jal_x29: got %h want 01", dut.rf_q[29]); else n_pass++;
  endtask

  task automatic test_io_load();
    E = 8'hD2;
    run_instr();
    n_checks++; if (readData !== 8'hD2) $display("FAIL lw_io_readData: got %h want d2", readData); else n_pass++;
    n_checks++; if (dut.rf_q[24] !== 8'hD2) $display("FAIL lw_io_x24: got %h want d2", dut.rf_q[24]); else n_pass++;
    n_checks++; if (pc !== 8'h7B) $display("FAIL lw_io_pc: got %h want 7b", pc); else n_pass++;
  endtask

  task automatic test_andi();
    run_instr();
    n_checks++; if ({srcA, srcB} !== 16'hD2AA) $display("FAIL andi_src: got %h want d2aa", {srcA, srcB}); else n_pass++;
    n_checks++; if (WD3 !== 8'h82) $display("FAIL andi_WD3: got %h want 82", WD3); else n_pass++;
    n_checks++; if (A3 !== 5'd29) $display("FAIL andi_A3: got %0d want 29", A3); else n_pass++;
    n_checks++; if (pc !== 8'h7C) $display("FAIL andi_pc: got %h want 7c", pc); else n_pass++;
  endtask

  task automatic test_store_ram();
    run_instr();
    n_checks++; if (dut.rf_q[1] !== 8'h5A) $display("FAIL addi_x1: got %h want 5a", dut.rf_q[1]); else n_pass++;
    run_instr();
    n_checks++; if (S !== 8'h5A) $display("FAIL sw_io_S: got %h want 5a", S); else n_pass++;
    n_checks++; if (A3 !== 5'd0) $display("FAIL sw_A3: got %0d want 0", A3); else n_pass++;
    run_instr();
    run_instr();
    n_checks++; if (dut.rf_q[2] !== 8'h5A) $display("FAIL ram_rt_x2: got %h want 5a", dut.rf_q[2]); else n_pass++;
    n_checks++; if (readData !== 8'h5A) $display("FAIL ram_rt_readData: got %h want 5a", readData); else n_pass++;
    n_checks++; if (S !== 8'h5A) $display("FAIL ram_rt_S_hold: got %h want 5a", S); else n_pass++;
  endtask

  task automatic test_arith();
    run_instr();
    n_checks++; if (dut.rf_q[3] !== 8'hFF) $display("FAIL addi_neg: got %h want ff", dut.rf_q[3]); else n_pass++;
    run_instr();
    n_checks++; if (dut.rf_q[3] !== 8'h00) $display("FAIL addi_wrap: got %h want 00", dut.rf_q[3]); else n_pass++;
    run_instr();
    n_checks++; if (dut.rf_q[0] !== 8'h00) $display("FAIL x0_write: got %h want 00", dut.rf_q[0]); else n_pass++;
    n_checks++; if (A3 !== 5'd0) $display("FAIL x0_A3: got %0d want 0", A3); else n_pass++;
  endtask

  task automatic test_branch();
    run_instr();
    n_checks++; if (pc !== 8'h85) $display("FAIL beq_taken_pc: got %h want 85", pc); else n_pass++;
    run_instr();
    n_checks++; if (pc !== 8'h86) $display("FAIL bne_not_taken_pc: got %h want 86", pc); else n_pass++;
  endtask

  task automatic test_alu_ops();
    logic [7:0] exp_v [6];
    exp_v = '{8'h2C, 8'h88, 8'h01, 8'hD0, 8'h0D, 8'h88};
    for (int k = 0; k < 6; k++) begin
      run_instr();
      n_checks++;
      if (dut.rf_q[5 + k] !== exp_v[k])
        $display("FAIL alu_op_x%0d: got %h want %h", 5 + k, dut.rf_q[5 + k], exp_v[k]);
      else n_pass++;
    end
  endtask

  task automatic test_nop_wrap();
    run_instr();
    n_checks++; if ({pc, 3'b000, A3} !== 16'h8D00) $display("FAIL nop_opcode: pc/A3 %h want 8d00", {pc, 3'b000, A3}); else n_pass++;
    run_instr();
    n_checks++; if (dut.rf_q[13] !== 8'h00) $display("FAIL nop_funct3_x13: got %h want 00", dut.rf_q[13]); else n_pass++;
    run_instr();
    n_checks++; if (pc !== 8'hFF) $display("FAIL jal_fwd_pc: got %h want ff", pc); else n_pass++;
    n_checks++; if (dut.rf_q[14] !== 8'h8F) $display("FAIL jal_fwd_link: got %h want 8f", dut.rf_q[14]); else n_pass++;
    run_instr();
    n_checks++; if (pc !== 8'h00) $display("FAIL pc_wrap: got %h want 00", pc); else n_pass++;
    n_checks++; if (dut.rf_q[11] !== 8'h07) $display("FAIL wrap_x11: got %h want 07", dut.rf_q[11]); else n_pass++;
  endtask

  task automatic test_mid_reset();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (4) run_instr();
    n_checks++; if (pc !== 8'h7D) $display("FAIL mr_pre_pc: got %h want 7d", pc); else n_pass++;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_checks++; if (pc !== 8'h00) $display("FAIL mr_async_pc: got %h want 00", pc); else n_pass++;
    n_checks++; if (dut.rf_q[1] !== 8'h00) $display("FAIL mr_async_x1: got %h want 00", dut.rf_q[1]); else n_pass++;
    @(posedge clock);
    @(negedge clock);
    n_checks++; if (S !== 8'h00) $display("FAIL mr_no_store_S: got %h want 00", S); else n_pass++;
    reset = 1'b1;
    run_instr();
    n_checks++; if (pc !== 8'h7A) $display("FAIL mr_restart_pc: got %h want 7a", pc); else n_pass++;
    n_checks++; if (S !== 8'h00) $display("FAIL mr_restart_S: got %h want 00", S); else n_pass++;
  endtask

  initial begin
    load_rom();
    test_reset();
    test_jump();
    test_io_load();
    test_andi();
    test_store_ram();
    test_arith();
    test_branch();
    test_alu_ops();
    test_nop_wrap();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
